// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and stall sequencer for the 5-stage core.
// Produces Execute forwarding selects, the load-use bubble, branch/jump
// flushes, and a memory-wait FSM that freezes the whole pipe while data
// memory is busy (sticky HALT on timeout).
// Optional build macro: PERF_CNT_EN adds stall_cnt/flush_cnt perf counters.
module hazard_ctrl #(
  parameter int unsigned WAIT_TIMEOUT = 16
`ifdef PERF_CNT_EN
  , parameter int unsigned CNT_WIDTH = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs1D,
  input  logic [4:0] rs2D,
  input  logic [4:0] rs1E,
  input  logic [4:0] rs2E,
  input  logic [4:0] rdE,
  input  logic [4:0] rdM,
  input  logic [4:0] rdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic [1:0] ResultSrcE,
  input  logic       PcSrcE,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       StallW,
  output logic       FlushD,
  output logic       FlushE,
  output logic       halt
`ifdef PERF_CNT_EN
  , output logic [CNT_WIDTH-1:0] stall_cnt
  , output logic [CNT_WIDTH-1:0] flush_cnt
`endif
);

  localparam int unsigned WCW = $clog2(WAIT_TIMEOUT) + 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [WCW-1:0] wait_cnt;
  logic [WCW-1:0] wait_cnt_nxt;
  logic           halt_nxt;
  logic           freeze;
  logic           lw_stall;

  // Forwarding select for one Execute source; Memory stage wins over Writeback.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       wr_m,
                                         input logic [4:0] rd_m,
                                         input logic       wr_w,
                                         input logic [4:0] rd_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // Execute operand forwarding, independent of FSM state.
  always_comb begin
    ForwardAE = fwd_sel(rs1E, RegWriteM, rdM, RegWriteW, rdW);
    ForwardBE = fwd_sel(rs2E, RegWriteM, rdM, RegWriteW, rdW);
  end

  // Load in Execute feeding an instruction in Decode needs one bubble.
  always_comb begin
    lw_stall = (ResultSrcE == 2'b01) && (rdE != 5'd0) &&
               ((rdE == rs1D) || (rdE == rs2D));
  end

  // Memory-wait FSM next state, wait counter and freeze decode.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    halt_nxt     = halt;
    freeze       = 1'b0;
    case (state)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          freeze       = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WCW'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else begin
          freeze = 1'b1;
          if (wait_cnt == WAIT_LAST) begin
            state_nxt = HALT;
            halt_nxt  = 1'b1;
          end else begin
            wait_cnt_nxt = wait_cnt + WCW'(1);
          end
        end
      end
      HALT: begin
        freeze = 1'b1;
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // Pipeline register enables; a memory freeze overrides bubbles and flushes.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    StallW = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (freeze) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      StallW = 1'b1;
    end else begin
      StallF = lw_stall;
      StallD = lw_stall;
      FlushD = PcSrcE;
      FlushE = lw_stall | PcSrcE;
    end
  end

  // FSM state, wait counter and sticky halt flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      halt     <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      halt     <= halt_nxt;
    end
  end

`ifdef PERF_CNT_EN
  // Saturating performance counters for stall and flush cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((freeze || lw_stall) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      end
      if (PcSrcE && !freeze && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed plus randomized checks of hazard_ctrl against a
// cycle-level behavioural model kept in the bench.
module tb_hazard_ctrl;

  localparam int unsigned WT = 4;
`ifdef PERF_CNT_EN
  localparam int unsigned CW = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic       RegWriteM, RegWriteW;
  logic [1:0] ResultSrcE;
  logic       PcSrcE, dmem_req, dmem_ready;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, halt;
`ifdef PERF_CNT_EN
  logic [CW-1:0] stall_cnt, flush_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: consecutive frozen cycles of the current access, halted flag, counters.
  int unsigned waited;
  bit          halted;
  int unsigned m_stall, m_flush;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .WAIT_TIMEOUT(WT)
`ifdef PERF_CNT_EN
    , .CNT_WIDTH(CW)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PcSrcE(PcSrcE),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE), .halt(halt)
`ifdef PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (RegWriteM && rdM != 0 && rdM == rs) return 2'b10;
    if (RegWriteW && rdW != 0 && rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_lw();
    return (ResultSrcE == 2'b01) && (rdE != 0) && (rdE == rs1D || rdE == rs2D);
  endfunction

  function automatic bit m_freeze();
    if (halted) return 1'b1;
    if (waited > 0) return !dmem_ready;
    return dmem_req && !dmem_ready;
  endfunction

  task automatic compare_all();
    bit fz, lw;
    logic [4:0] st;
    logic [1:0] fl;
    fz = m_freeze();
    lw = m_lw();
    st = fz ? 5'b11111 : {lw, lw, 3'b000};
    fl = fz ? 2'b00 : {PcSrcE, lw | PcSrcE};
    check("fwdA", 32'(ForwardAE), 32'(m_fwd(rs1E)));
    check("fwdB", 32'(ForwardBE), 32'(m_fwd(rs2E)));
    check("stall", 32'({StallF, StallD, StallE, StallM, StallW}), 32'(st));
    check("flush", 32'({FlushD, FlushE}), 32'(fl));
    check("halt", 32'(halt), 32'(halted));
`ifdef PERF_CNT_EN
    check("stall_cnt", 32'(stall_cnt), m_stall);
    check("flush_cnt", 32'(flush_cnt), m_flush);
`endif
  endtask

  task automatic model_update();
    bit fz;
    fz = m_freeze();
`ifdef PERF_CNT_EN
    if ((fz || m_lw()) && m_stall < CMAX) m_stall++;
    if (PcSrcE && !fz && m_flush < CMAX) m_flush++;
`endif
    if (!halted) begin
      if (fz) begin
        waited++;
        if (waited >= WT) halted = 1'b1;
      end else begin
        waited = 0;
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    compare_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic zero_inputs();
    rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PcSrcE = 0;
    dmem_req = 0; dmem_ready = 1;
  endtask

  task automatic do_reset();
    zero_inputs();
    rst = 1'b1;
    #2;
    waited = 0; halted = 0; m_stall = 0; m_flush = 0;
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_stall", 32'({StallF, StallD, StallE, StallM, StallW}), 32'd0);
    check("rst_flush", 32'({FlushD, FlushE}), 32'd0);
    check("rst_fwd", 32'({ForwardAE, ForwardBE}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    advance();
  endtask

  initial begin
    zero_inputs();
    rst = 1'b1;
    #1;
    do_reset();

    // Forward priority
    rs1E = 5; rdM = 5; rdW = 5; RegWriteM = 1; RegWriteW = 1;
    settle(); check("t1_fwd_m", 32'(ForwardAE), 32'b10); advance();
    RegWriteM = 0;
    settle(); check("t1_fwd_w", 32'(ForwardAE), 32'b01); advance();
    rdW = 0;
    settle(); check("t1_fwd_zero", 32'(ForwardAE), 32'b00); advance();
    zero_inputs();

    // Load-use bubble then drop once the load reaches Memory
    ResultSrcE = 2'b01; rdE = 7; rs2D = 7;
    settle();
    check("t2_stall", 32'({StallF, StallD, StallE, StallM, StallW}), 32'b11000);
    check("t2_flushE", 32'(FlushE), 32'd1);
    check("t2_fwdB", 32'(ForwardBE), 32'b00);
    advance();
    ResultSrcE = 0; rdE = 0; rs2D = 0; rdM = 7; RegWriteM = 1; rs2E = 7;
    settle();
    check("t2_release", 32'({StallF, StallD, FlushE}), 32'd0);
    check("t2_fwdB_m", 32'(ForwardBE), 32'b10);
    advance();
    zero_inputs();

    // Memory wait, 3 not-ready cycles, branch pulse swallowed by the freeze
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      PcSrcE = (i == 1);
      settle();
      check("t4_freeze", 32'({StallF, StallD, StallE, StallM, StallW}), 32'b11111);
      check("t4_flushD", 32'(FlushD), 32'd0);
      advance();
    end
    PcSrcE = 0; dmem_ready = 1;
    settle(); check("t4_ready", 32'({StallF, StallE, StallW}), 32'd0); advance();
    dmem_req = 0;
    settle(); check("t4_run", 32'({StallF, StallM, halt}), 32'd0); advance();
`ifdef PERF_CNT_EN
    check("t6_stall_cnt", 32'(stall_cnt), 32'd4);
    check("t6_flush_cnt", 32'(flush_cnt), 32'd0);
`endif

    // Branch flush
    PcSrcE = 1;
    settle();
    check("t3_flush", 32'({FlushD, FlushE}), 32'b11);
    check("t3_stallF", 32'(StallF), 32'd0);
    advance();
    PcSrcE = 0;

    // Reset in the middle of a memory wait
    dmem_req = 1; dmem_ready = 0;
    settle(); advance();
    settle(); advance();
    do_reset();
    settle(); check("rst_midwait", 32'(StallF), 32'd0); advance();

    // Timeout into HALT, stays frozen, then counter saturation while halted
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      settle(); check("t5_freeze", 32'(StallW), 32'd1); advance();
    end
    dmem_req = 0; dmem_ready = 1;
    settle();
    check("t5_halt", 32'(halt), 32'd1);
    check("t5_frozen", 32'({StallF, StallD, StallE, StallM, StallW}), 32'b11111);
    advance();
    for (int i = 0; i < 15; i++) begin
      settle(); advance();
    end
`ifdef PERF_CNT_EN
    check("t6_saturate", 32'(stall_cnt), 32'(CMAX));
`endif
    do_reset();
    settle(); check("t5_cleared", 32'(halt), 32'd0); advance();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3));
      rs1E = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3));
      rdE  = 5'($urandom_range(0, 3)); rdM  = 5'($urandom_range(0, 3));
      rdW  = 5'($urandom_range(0, 3));
      RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
      ResultSrcE = 2'($urandom_range(0, 3));
      PcSrcE = ($urandom_range(0, 4) == 0);
      dmem_req = ($urandom_range(0, 2) == 0);
      dmem_ready = ($urandom_range(0, 9) < 6);
      settle();
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
